// File: rtl/fb_arb_pkg.sv
// Shared types and default sizing for the FrameBuffer port arbiter.
package fb_arb_pkg;

  localparam int FB_ADDR_W          = 20;
  localparam int FB_DATA_W          = 16;
  localparam int FB_MAX_OUTSTANDING = 4;
  localparam int FB_MAX_VIDEO_RUN   = 8;

  typedef enum logic {
    OWN_VID  = 1'b0,
    OWN_HOST = 1'b1
  } owner_t;

  typedef enum logic [1:0] {
    GNT_NONE    = 2'd0,
    GNT_VID_RD  = 2'd1,
    GNT_HOST_RD = 2'd2,
    GNT_HOST_WR = 2'd3
  } grant_t;

endpackage

// File: rtl/fb_arb_tag_fifo.sv
// Owner-tag FIFO: one bit per outstanding read, returned in issue order.
module fb_arb_tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     push_owner,
  input  logic                     pop,
  output logic                     pop_owner,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == (PW+1)'(DEPTH));
  // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign pop_owner = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_owner;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fb_arbiter.sv
// Arbitrates the FrameBuffer port between video scan-out (priority) and the host,
// registers the winning command and routes read returns back by owner tag.
module fb_arbiter
  import fb_arb_pkg::*;
#(
  parameter int ADDR_W          = FB_ADDR_W,
  parameter int DATA_W          = FB_DATA_W,
  parameter int MAX_OUTSTANDING = FB_MAX_OUTSTANDING,
  parameter int MAX_VIDEO_RUN   = FB_MAX_VIDEO_RUN
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] vid_address,
  input  logic              vid_read,
  output logic              vid_waitrequest,
  output logic [DATA_W-1:0] vid_readdata,
  output logic              vid_readdatavalid,
  input  logic [ADDR_W-1:0] host_address,
  input  logic [1:0]        host_byteenable,
  input  logic              host_read,
  input  logic              host_write,
  input  logic [DATA_W-1:0] host_writedata,
  output logic              host_waitrequest,
  output logic [DATA_W-1:0] host_readdata,
  output logic              host_readdatavalid,
  output logic [ADDR_W-1:0] fb_address,
  output logic [1:0]        fb_byteenable,
  output logic              fb_read,
  output logic              fb_write,
  output logic [DATA_W-1:0] fb_writedata,
  input  logic [DATA_W-1:0] fb_readdata,
  input  logic              fb_readdatavalid,
  output logic              orphan_err
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int RUN_W = $clog2(MAX_VIDEO_RUN + 1);

  grant_t           grant;
  logic [RUN_W-1:0] vid_run;
  logic             vid_run_max;
  logic             rd_ok;
  logic             vid_elig;
  logic             host_elig;
  logic             host_granted;
  logic             rd_granted;
  logic [CNT_W-1:0] tag_count;
  logic             tag_empty;
  logic             tag_full;
  logic             tag_pop_owner;
  owner_t           ret_owner;

  assign rd_ok       = (tag_count < CNT_W'(MAX_OUTSTANDING));
  assign vid_elig    = vid_read & rd_ok;
  assign host_elig   = host_write | (host_read & rd_ok);
  assign vid_run_max = (vid_run == RUN_W'(MAX_VIDEO_RUN));

  // Write wins over read when the host raises both; the read is simply not serviced.
  always_comb begin
    grant = GNT_NONE;
    if (host_elig && (!vid_elig || vid_run_max)) begin
      grant = host_write ? GNT_HOST_WR : GNT_HOST_RD;
    end else if (vid_elig) begin
      grant = GNT_VID_RD;
    end
  end

  assign host_granted     = (grant == GNT_HOST_RD) || (grant == GNT_HOST_WR);
  assign rd_granted       = (grant == GNT_HOST_RD) || (grant == GNT_VID_RD);
  assign vid_waitrequest  = (grant != GNT_VID_RD);
  assign host_waitrequest = ~host_granted;

  fb_arb_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (rd_granted & ~tag_full),
    .push_owner (grant == GNT_HOST_RD),
    .pop        (fb_readdatavalid),
    .pop_owner  (tag_pop_owner),
    .count      (tag_count),
    .empty      (tag_empty),
    .full       (tag_full)
  );

  assign ret_owner = owner_t'(tag_pop_owner);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vid_run <= '0;
    end else if (!vid_read || host_granted) begin
      vid_run <= '0;
    end else if ((grant == GNT_VID_RD) && !vid_run_max) begin
      vid_run <= vid_run + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fb_address    <= '0;
      fb_byteenable <= '0;
      fb_read       <= 1'b0;
      fb_write      <= 1'b0;
      fb_writedata  <= '0;
    end else begin
      fb_read  <= 1'b0;
      fb_write <= 1'b0;
      unique case (grant)
        GNT_VID_RD: begin
          fb_read       <= 1'b1;
          fb_address    <= vid_address;
          fb_byteenable <= 2'b11;
        end
        GNT_HOST_RD: begin
          fb_read       <= 1'b1;
          fb_address    <= host_address;
          fb_byteenable <= host_byteenable;
        end
        GNT_HOST_WR: begin
          fb_write      <= 1'b1;
          fb_address    <= host_address;
          fb_byteenable <= host_byteenable;
          fb_writedata  <= host_writedata;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vid_readdatavalid  <= 1'b0;
      vid_readdata       <= '0;
      host_readdatavalid <= 1'b0;
      host_readdata      <= '0;
      orphan_err         <= 1'b0;
    end else begin
      vid_readdatavalid  <= 1'b0;
      host_readdatavalid <= 1'b0;
      if (fb_readdatavalid) begin
        if (tag_empty) begin
          orphan_err <= 1'b1;
        end else if (ret_owner == OWN_HOST) begin
          host_readdatavalid <= 1'b1;
          host_readdata      <= fb_readdata;
        end else begin
          vid_readdatavalid  <= 1'b1;
          vid_readdata       <= fb_readdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a small FrameBuffer responder model.
module tb_fb_arbiter;

  localparam int AW = 20;
  localparam int DW = 16;

  logic          clk;
  logic          reset_n;
  logic [AW-1:0] vid_address;
  logic          vid_read;
  logic          vid_waitrequest;
  logic [DW-1:0] vid_readdata;
  logic          vid_readdatavalid;
  logic [AW-1:0] host_address;
  logic [1:0]    host_byteenable;
  logic          host_read;
  logic          host_write;
  logic [DW-1:0] host_writedata;
  logic          host_waitrequest;
  logic [DW-1:0] host_readdata;
  logic          host_readdatavalid;
  logic [AW-1:0] fb_address;
  logic [1:0]    fb_byteenable;
  logic          fb_read;
  logic          fb_write;
  logic [DW-1:0] fb_writedata;
  logic [DW-1:0] fb_readdata;
  logic          fb_readdatavalid;
  logic          orphan_err;

  fb_arbiter #(
    .ADDR_W          (AW),
    .DATA_W          (DW),
    .MAX_OUTSTANDING (4),
    .MAX_VIDEO_RUN   (8)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .vid_address        (vid_address),
    .vid_read           (vid_read),
    .vid_waitrequest    (vid_waitrequest),
    .vid_readdata       (vid_readdata),
    .vid_readdatavalid  (vid_readdatavalid),
    .host_address       (host_address),
    .host_byteenable    (host_byteenable),
    .host_read          (host_read),
    .host_write         (host_write),
    .host_writedata     (host_writedata),
    .host_waitrequest   (host_waitrequest),
    .host_readdata      (host_readdata),
    .host_readdatavalid (host_readdatavalid),
    .fb_address         (fb_address),
    .fb_byteenable      (fb_byteenable),
    .fb_read            (fb_read),
    .fb_write           (fb_write),
    .fb_writedata       (fb_writedata),
    .fb_readdata        (fb_readdata),
    .fb_readdatavalid   (fb_readdatavalid),
    .orphan_err         (orphan_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
    return a[DW-1:0] ^ 16'h5A5A;
  endfunction

  // Responder: auto mode returns data two cycles after fb_read; otherwise stalls
  // and only returns words queued in inj_q, one per cycle.
  logic          auto_resp;
  logic [DW-1:0] inj_q[$];
  logic [DW-1:0] vid_got[$];
  logic [DW-1:0] host_got[$];
  logic [AW-1:0] rd_addr_q[$];
  int            fb_read_cnt  = 0;
  int            fb_write_cnt = 0;
  logic          p0_v, p1_v;
  logic [DW-1:0] p0_d, p1_d;

  initial begin
    fb_readdatavalid = 1'b0;
    fb_readdata      = '0;
    p0_v = 1'b0; p1_v = 1'b0; p0_d = '0; p1_d = '0;
    forever begin
      @(negedge clk);
      if (vid_readdatavalid)  vid_got.push_back(vid_readdata);
      if (host_readdatavalid) host_got.push_back(host_readdata);
      if (fb_read) begin
        fb_read_cnt++;
        rd_addr_q.push_back(fb_address);
      end
      if (fb_write) fb_write_cnt++;
      fb_readdatavalid = 1'b0;
      if (auto_resp) begin
        fb_readdatavalid = p1_v;
        fb_readdata      = p1_d;
        p1_v = p0_v; p1_d = p0_d;
        p0_v = fb_read; p0_d = mem_data(fb_address);
      end else begin
        p0_v = 1'b0; p1_v = 1'b0;
        if (inj_q.size() > 0) begin
          fb_readdatavalid = 1'b1;
          fb_readdata      = inj_q.pop_front();
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int r0, w0, v0, h0, a0;

  initial begin
    auto_resp = 1'b1;
    reset_n = 1'b0;
    vid_address = '0; vid_read = 1'b0;
    host_address = '0; host_byteenable = '0; host_read = 1'b0; host_write = 1'b0;
    host_writedata = '0;
    repeat (3) @(negedge clk);
    check("rst_vid_wr",   32'(vid_waitrequest), 32'd1);
    check("rst_host_wr",  32'(host_waitrequest), 32'd1);
    check("rst_fb_read",  32'(fb_read), 32'd0);
    check("rst_fb_write", 32'(fb_write), 32'd0);
    check("rst_vid_rdv",  32'(vid_readdatavalid), 32'd0);
    check("rst_orphan",   32'(orphan_err), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: VID only, 16 reads in address order
    r0 = fb_read_cnt; v0 = vid_got.size(); h0 = host_got.size(); a0 = rd_addr_q.size();
    for (int i = 0; i < 16; i++) begin
      vid_read = 1'b1;
      vid_address = 20'h00100 + AW'(i);
      #1 check("t1_vid_acc", 32'(vid_waitrequest), 32'd0);
      @(negedge clk);
    end
    vid_read = 1'b0;
    repeat (8) @(negedge clk);
    check("t1_fb_reads", 32'(fb_read_cnt - r0), 32'd16);
    check("t1_vid_rdv",  32'(vid_got.size() - v0), 32'd16);
    check("t1_host_rdv", 32'(host_got.size() - h0), 32'd0);
    for (int i = 0; i < 16; i++) begin
      if (vid_got.size() > v0 + i)
        check("t1_data", 32'(vid_got[v0 + i]), 32'(mem_data(20'h00100 + AW'(i))));
      if (rd_addr_q.size() > a0 + i)
        check("t1_addr", 32'(rd_addr_q[a0 + i]), 32'h00100 + 32'(i));
    end

    // 2: both reading, 8 VID then 1 HOST
    v0 = vid_got.size(); h0 = host_got.size();
    vid_read = 1'b1; vid_address = 20'h00300;
    host_read = 1'b1; host_address = 20'h00200; host_byteenable = 2'b11;
    for (int k = 0; k < 27; k++) begin
      #1;
      check("t2_host_wr", 32'(host_waitrequest), (k % 9 == 8) ? 32'd0 : 32'd1);
      check("t2_vid_wr",  32'(vid_waitrequest),  (k % 9 == 8) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    vid_read = 1'b0; host_read = 1'b0;
    repeat (8) @(negedge clk);
    check("t2_vid_rdv",  32'(vid_got.size() - v0), 32'd24);
    check("t2_host_rdv", 32'(host_got.size() - h0), 32'd3);
    for (int i = 0; i < 3; i++)
      if (host_got.size() > h0 + i)
        check("t2_host_data", 32'(host_got[h0 + i]), 32'(mem_data(20'h00200)));

    // 3: stalled FrameBuffer, tags exhausted, write still flows
    auto_resp = 1'b0;
    @(negedge clk);
    vid_read = 1'b1; vid_address = 20'h00400;
    for (int k = 0; k < 4; k++) begin
      #1 check("t3_vid_acc", 32'(vid_waitrequest), 32'd0);
      @(negedge clk);
    end
    host_read = 1'b1; host_address = 20'h00500;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t3_vid_blk",  32'(vid_waitrequest), 32'd1);
      check("t3_host_blk", 32'(host_waitrequest), 32'd1);
      @(negedge clk);
    end
    host_read = 1'b0; host_write = 1'b1; host_address = 20'h00ABC;
    host_writedata = 16'h1234; host_byteenable = 2'b01;
    #1 check("t3_host_wr_acc", 32'(host_waitrequest), 32'd0);
    @(negedge clk);
    host_write = 1'b0; vid_read = 1'b0;
    check("t3_fb_write", 32'(fb_write), 32'd1);
    check("t3_fb_read",  32'(fb_read), 32'd0);
    check("t3_fb_wdata", 32'(fb_writedata), 32'h1234);
    check("t3_fb_be",    32'(fb_byteenable), 32'h1);
    check("t3_fb_addr",  32'(fb_address), 32'h00ABC);
    @(negedge clk);
    check("t3_fb_write_pulse", 32'(fb_write), 32'd0);
    v0 = vid_got.size();
    for (int i = 0; i < 4; i++) inj_q.push_back(16'hD000 + 16'(i));
    repeat (8) @(negedge clk);
    check("t3_drain_cnt", 32'(vid_got.size() - v0), 32'd4);
    for (int i = 0; i < 4; i++)
      if (vid_got.size() > v0 + i)
        check("t3_drain_data", 32'(vid_got[v0 + i]), 32'hD000 + 32'(i));

    // 4: V,H,V reads, returns A,B,C routed by tag
    v0 = vid_got.size(); h0 = host_got.size();
    vid_read = 1'b1; vid_address = 20'h00600;
    #1 check("t4_v1_acc", 32'(vid_waitrequest), 32'd0);
    @(negedge clk);
    vid_read = 1'b0; host_read = 1'b1; host_address = 20'h00700;
    #1 check("t4_h_acc", 32'(host_waitrequest), 32'd0);
    @(negedge clk);
    host_read = 1'b0; vid_read = 1'b1; vid_address = 20'h00601;
    #1 check("t4_v2_acc", 32'(vid_waitrequest), 32'd0);
    @(negedge clk);
    vid_read = 1'b0;
    inj_q.push_back(16'hAAAA); inj_q.push_back(16'hBBBB); inj_q.push_back(16'hCCCC);
    repeat (8) @(negedge clk);
    check("t4_vid_cnt",  32'(vid_got.size() - v0), 32'd2);
    check("t4_host_cnt", 32'(host_got.size() - h0), 32'd1);
    if (vid_got.size() > v0 + 1) begin
      check("t4_vid_a", 32'(vid_got[v0]), 32'hAAAA);
      check("t4_vid_c", 32'(vid_got[v0 + 1]), 32'hCCCC);
    end
    if (host_got.size() > h0) check("t4_host_b", 32'(host_got[h0]), 32'hBBBB);

    // 6: read+write together is a single write with no tag
    r0 = fb_read_cnt; w0 = fb_write_cnt; h0 = host_got.size();
    host_read = 1'b1; host_write = 1'b1; host_address = 20'h00010;
    host_writedata = 16'h5555; host_byteenable = 2'b11;
    #1 check("t6_host_acc", 32'(host_waitrequest), 32'd0);
    @(negedge clk);
    host_read = 1'b0; host_write = 1'b0;
    check("t6_fb_write", 32'(fb_write), 32'd1);
    check("t6_fb_read",  32'(fb_read), 32'd0);
    check("t6_fb_addr",  32'(fb_address), 32'h00010);
    repeat (3) @(negedge clk);
    check("t6_reads",  32'(fb_read_cnt - r0), 32'd0);
    check("t6_writes", 32'(fb_write_cnt - w0), 32'd1);
    check("t6_orphan_pre", 32'(orphan_err), 32'd0);
    inj_q.push_back(16'hEEEE);
    repeat (4) @(negedge clk);
    check("t6_no_tag",   32'(orphan_err), 32'd1);
    check("t6_host_rdv", 32'(host_got.size() - h0), 32'd0);

    // 5: reset with 3 reads in flight, late return is an orphan
    v0 = vid_got.size(); h0 = host_got.size();
    vid_read = 1'b1; vid_address = 20'h00800;
    for (int k = 0; k < 3; k++) begin
      #1 check("t5_vid_acc", 32'(vid_waitrequest), 32'd0);
      @(negedge clk);
    end
    vid_read = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("t5_rst_orphan", 32'(orphan_err), 32'd0);
    check("t5_rst_vid_wr", 32'(vid_waitrequest), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    inj_q.push_back(16'h7777);
    repeat (4) @(negedge clk);
    check("t5_orphan",   32'(orphan_err), 32'd1);
    check("t5_vid_rdv",  32'(vid_got.size() - v0), 32'd0);
    check("t5_host_rdv", 32'(host_got.size() - h0), 32'd0);
    repeat (5) @(negedge clk);
    check("t5_orphan_sticky", 32'(orphan_err), 32'd1);
    reset_n = 1'b0;
    #1 check("t5_orphan_clr", 32'(orphan_err), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
